// File: rtl/compuertas_secuenciador.sv
// compuertas_secuenciador
//   Self-test sequencer for a 3-input selectable logic-gate unit. On a start
//   request it enables the unit and sweeps function codes SEL_INI..SEL_FIN
//   (1=AND 2=OR 3=XOR 4=NAND 5=NOR 6=XNOR) over all eight input vectors.
//   Each vector is held ESPERA cycles before sal is sampled. The sampled bit
//   is stored in tabla and checked against a locally computed golden value.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   inicio                start pulse, sampled only while idle
//   cancelar              abort request while a sweep is running
//   sal                   gate unit output
//   ent1, ent2, ent3      gate unit inputs, {ent1,ent2,ent3} = vector index
//   act, sel              gate unit enable and function select
//   ocupado, listo        sweep in progress / one-cycle completion pulse
//   tabla                 captured truth table, bit (sel-1)*8+idx
//   error, err_sel, err_ent  sticky mismatch flag and first mismatch location
module compuertas_secuenciador #(
    parameter int ESPERA  = 2,
    parameter int SEL_INI = 1,
    parameter int SEL_FIN = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inicio,
    input  logic        cancelar,
    input  logic        sal,
    output logic        ent1,
    output logic        ent2,
    output logic        ent3,
    output logic        act,
    output logic [2:0]  sel,
    output logic        ocupado,
    output logic        listo,
    output logic [47:0] tabla,
    output logic        error,
    output logic [2:0]  err_sel,
    output logic [2:0]  err_ent
);

    typedef enum logic [1:0] {
        ST_REPOSO  = 2'd0,
        ST_ESPERA  = 2'd1,
        ST_CAPTURA = 2'd2,
        ST_FIN     = 2'd3
    } estado_t;

    localparam logic [3:0] CNT_FIN = 4'(ESPERA - 1);
    localparam logic [2:0] SEL_INI_L = 3'(SEL_INI);
    localparam logic [2:0] SEL_FIN_L = 3'(SEL_FIN);

    estado_t     estado_r, estado_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [2:0]  idx_r, idx_s;
    logic [2:0]  sel_r, sel_s;
    logic        act_r, act_s;
    logic        ocupado_r, ocupado_s;
    logic        listo_r, listo_s;
    logic [47:0] tabla_r, tabla_s;
    logic        error_r, error_s;
    logic [2:0]  err_sel_r, err_sel_s;
    logic [2:0]  err_ent_r, err_ent_s;
    logic [5:0]  pos_s;

    // Expected gate output for function code f applied to vector v.
    function automatic logic golden(input logic [2:0] f, input logic [2:0] v);
        logic g;
        case (f)
            3'd1:    g = &v;
            3'd2:    g = |v;
            3'd3:    g = ^v;
            3'd4:    g = ~&v;
            3'd5:    g = ~|v;
            3'd6:    g = ~^v;
            default: g = 1'b0;
        endcase
        return g;
    endfunction

    // Next-state and next-output computation for the sweep FSM.
    always_comb begin
        estado_s  = estado_r;
        cnt_s     = cnt_r;
        idx_s     = idx_r;
        sel_s     = sel_r;
        act_s     = act_r;
        ocupado_s = ocupado_r;
        listo_s   = 1'b0;
        tabla_s   = tabla_r;
        error_s   = error_r;
        err_sel_s = err_sel_r;
        err_ent_s = err_ent_r;
        // (sel-1)*8+idx is just the concatenation of the two fields
        pos_s     = {sel_r - 3'd1, idx_r};

        case (estado_r)
            ST_REPOSO: begin
                if (inicio) begin
                    estado_s  = ST_ESPERA;
                    sel_s     = SEL_INI_L;
                    idx_s     = 3'd0;
                    cnt_s     = 4'd0;
                    act_s     = 1'b1;
                    ocupado_s = 1'b1;
                    error_s   = 1'b0;
                    err_sel_s = 3'd0;
                    err_ent_s = 3'd0;
                end else begin
                    estado_s = ST_REPOSO;
                end
            end
            ST_ESPERA: begin
                if (cancelar) begin
                    estado_s  = ST_REPOSO;
                    act_s     = 1'b0;
                    sel_s     = 3'd0;
                    idx_s     = 3'd0;
                    cnt_s     = 4'd0;
                    ocupado_s = 1'b0;
                end else if (cnt_r == CNT_FIN) begin
                    estado_s = ST_CAPTURA;
                    cnt_s    = cnt_r + 4'd1;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            ST_CAPTURA: begin
                // an abort in the capture cycle drops the capture entirely
                if (cancelar) begin
                    estado_s  = ST_REPOSO;
                    act_s     = 1'b0;
                    sel_s     = 3'd0;
                    idx_s     = 3'd0;
                    cnt_s     = 4'd0;
                    ocupado_s = 1'b0;
                end else begin
                    tabla_s[pos_s] = sal;
                    if ((sal != golden(sel_r, idx_r)) && !error_r) begin
                        error_s   = 1'b1;
                        err_sel_s = sel_r;
                        err_ent_s = idx_r;
                    end else begin
                        error_s = error_r;
                    end
                    if (idx_r != 3'd7) begin
                        idx_s    = idx_r + 3'd1;
                        cnt_s    = 4'd0;
                        estado_s = ST_ESPERA;
                    end else if (sel_r != SEL_FIN_L) begin
                        idx_s    = 3'd0;
                        sel_s    = sel_r + 3'd1;
                        cnt_s    = 4'd0;
                        estado_s = ST_ESPERA;
                    end else begin
                        estado_s  = ST_FIN;
                        listo_s   = 1'b1;
                        act_s     = 1'b0;
                        sel_s     = 3'd0;
                        idx_s     = 3'd0;
                        cnt_s     = 4'd0;
                        ocupado_s = 1'b0;
                    end
                end
            end
            ST_FIN: begin
                estado_s = ST_REPOSO;
            end
            default: begin
                estado_s  = ST_REPOSO;
                act_s     = 1'b0;
                sel_s     = 3'd0;
                idx_s     = 3'd0;
                cnt_s     = 4'd0;
                ocupado_s = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_r  <= ST_REPOSO;
            cnt_r     <= 4'd0;
            idx_r     <= 3'd0;
            sel_r     <= 3'd0;
            act_r     <= 1'b0;
            ocupado_r <= 1'b0;
            listo_r   <= 1'b0;
            tabla_r   <= 48'd0;
            error_r   <= 1'b0;
            err_sel_r <= 3'd0;
            err_ent_r <= 3'd0;
        end else begin
            estado_r  <= estado_s;
            cnt_r     <= cnt_s;
            idx_r     <= idx_s;
            sel_r     <= sel_s;
            act_r     <= act_s;
            ocupado_r <= ocupado_s;
            listo_r   <= listo_s;
            tabla_r   <= tabla_s;
            error_r   <= error_s;
            err_sel_r <= err_sel_s;
            err_ent_r <= err_ent_s;
        end
    end

    assign {ent1, ent2, ent3} = idx_r;
    assign act     = act_r;
    assign sel     = sel_r;
    assign ocupado = ocupado_r;
    assign listo   = listo_r;
    assign tabla   = tabla_r;
    assign error   = error_r;
    assign err_sel = err_sel_r;
    assign err_ent = err_ent_r;

endmodule

// File: tb/tb_compuertas_secuenciador.sv
// Bench for compuertas_secuenciador: two instances (default sweep, and a
// single-function sweep with ESPERA=1), each driving a gate model with
// optional injected faults. A timing-level model predicts every output
// each cycle; directed tests pin absolute truth tables and cycle counts.
module tb_compuertas_secuenciador;

    localparam int E0 = 2, I0 = 1, F0 = 6;
    localparam int E1 = 1, I1 = 4, F1 = 4;

    logic clk, rst;
    logic [1:0] inicio_v, cancel_v;
    logic flt_xor3, flt_nor0;

    logic d0_sal, d0_e1, d0_e2, d0_e3, d0_act, d0_ocupado, d0_listo, d0_error;
    logic [2:0] d0_sel, d0_err_sel, d0_err_ent;
    logic [47:0] d0_tabla;
    logic d1_sal, d1_e1, d1_e2, d1_e3, d1_act, d1_ocupado, d1_listo, d1_error;
    logic [2:0] d1_sel, d1_err_sel, d1_err_ent;
    logic [47:0] d1_tabla;

    int total = 0;
    int bad = 0;

    // model state, one entry per instance
    logic        m_busy [2];
    logic        m_listo [2];
    int          m_t [2];
    logic [47:0] m_tabla [2];
    logic        m_error [2];
    logic [2:0]  m_err_sel [2];
    logic [2:0]  m_err_ent [2];

    // Gate function from its truth: count of ones in the vector.
    function automatic logic golden_bit(input logic [2:0] f, input logic [2:0] v);
        int n;
        n = $countones(v);
        case (f)
            3'd1:    return n == 3;
            3'd2:    return n > 0;
            3'd3:    return (n % 2) == 1;
            3'd4:    return n != 3;
            3'd5:    return n == 0;
            3'd6:    return (n % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    // Gate unit under test, with optional faults at XOR/v3 and NOR/v0.
    function automatic logic gate_bit(input logic a, input logic [2:0] s, input logic [2:0] v,
                                      input logic fx, input logic fn);
        logic r;
        if (!a) return 1'b0;
        r = golden_bit(s, v);
        if (fx && s == 3'd3 && v == 3'd3) r = ~r;
        if (fn && s == 3'd5 && v == 3'd0) r = ~r;
        return r;
    endfunction

    function automatic int vlen(input int u);
        return (u == 0) ? E0 + 1 : E1 + 1;
    endfunction
    function automatic int t_last(input int u);
        return (u == 0) ? (F0 - I0 + 1) * 8 * (E0 + 1) - 1 : (F1 - I1 + 1) * 8 * (E1 + 1) - 1;
    endfunction
    function automatic logic [2:0] e_sel(input int u, input int t);
        int ini;
        ini = (u == 0) ? I0 : I1;
        return 3'(ini + (t / vlen(u)) / 8);
    endfunction
    function automatic logic [2:0] e_idx(input int u, input int t);
        return 3'((t / vlen(u)) % 8);
    endfunction
    function automatic int cap_pos(input int u, input int t);
        return (int'(e_sel(u, t)) - 1) * 8 + int'(e_idx(u, t));
    endfunction
    function automatic logic is_cap(input int u, input int t);
        return (t % vlen(u)) == vlen(u) - 1;
    endfunction

    assign d0_sal = gate_bit(d0_act, d0_sel, {d0_e1, d0_e2, d0_e3}, flt_xor3, flt_nor0);
    assign d1_sal = gate_bit(d1_act, d1_sel, {d1_e1, d1_e2, d1_e3}, flt_xor3, flt_nor0);

    compuertas_secuenciador #(.ESPERA(E0), .SEL_INI(I0), .SEL_FIN(F0)) dut0 (
        .clk(clk), .rst(rst), .inicio(inicio_v[0]), .cancelar(cancel_v[0]), .sal(d0_sal),
        .ent1(d0_e1), .ent2(d0_e2), .ent3(d0_e3), .act(d0_act), .sel(d0_sel),
        .ocupado(d0_ocupado), .listo(d0_listo), .tabla(d0_tabla), .error(d0_error),
        .err_sel(d0_err_sel), .err_ent(d0_err_ent)
    );

    compuertas_secuenciador #(.ESPERA(E1), .SEL_INI(I1), .SEL_FIN(F1)) dut1 (
        .clk(clk), .rst(rst), .inicio(inicio_v[1]), .cancelar(cancel_v[1]), .sal(d1_sal),
        .ent1(d1_e1), .ent2(d1_e2), .ent3(d1_e3), .act(d1_act), .sel(d1_sel),
        .ocupado(d1_ocupado), .listo(d1_listo), .tabla(d1_tabla), .error(d1_error),
        .err_sel(d1_err_sel), .err_ent(d1_err_ent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Model: sweep position t advances one per busy cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < 2; u++) begin
                m_busy[u] <= 1'b0; m_listo[u] <= 1'b0; m_t[u] <= 0; m_tabla[u] <= 48'd0;
                m_error[u] <= 1'b0; m_err_sel[u] <= 3'd0; m_err_ent[u] <= 3'd0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                if (m_listo[u]) begin
                    m_listo[u] <= 1'b0;
                end else if (!m_busy[u]) begin
                    if (inicio_v[u]) begin
                        m_busy[u] <= 1'b1; m_t[u] <= 0; m_error[u] <= 1'b0;
                        m_err_sel[u] <= 3'd0; m_err_ent[u] <= 3'd0;
                    end
                end else if (cancel_v[u]) begin
                    m_busy[u] <= 1'b0;
                end else begin
                    if (is_cap(u, m_t[u])) begin
                        m_tabla[u][cap_pos(u, m_t[u])] <=
                            gate_bit(1'b1, e_sel(u, m_t[u]), e_idx(u, m_t[u]), flt_xor3, flt_nor0);
                        if (gate_bit(1'b1, e_sel(u, m_t[u]), e_idx(u, m_t[u]), flt_xor3, flt_nor0)
                                != golden_bit(e_sel(u, m_t[u]), e_idx(u, m_t[u])) && !m_error[u]) begin
                            m_error[u] <= 1'b1;
                            m_err_sel[u] <= e_sel(u, m_t[u]);
                            m_err_ent[u] <= e_idx(u, m_t[u]);
                        end
                    end
                    if (m_t[u] == t_last(u)) begin
                        m_busy[u] <= 1'b0; m_listo[u] <= 1'b1;
                    end else begin
                        m_t[u] <= m_t[u] + 1;
                    end
                end
            end
        end
    end

    task automatic cmp_unit(input int u, input logic oc, input logic ac, input logic [2:0] s,
                            input logic [2:0] e, input logic li, input logic [47:0] tb_v,
                            input logic er, input logic [2:0] es, input logic [2:0] ee);
        check($sformatf("u%0d ocupado", u), 48'(oc), 48'(m_busy[u]));
        check($sformatf("u%0d act", u), 48'(ac), 48'(m_busy[u]));
        check($sformatf("u%0d sel", u), 48'(s), 48'(m_busy[u] ? e_sel(u, m_t[u]) : 3'd0));
        check($sformatf("u%0d ent", u), 48'(e), 48'(m_busy[u] ? e_idx(u, m_t[u]) : 3'd0));
        check($sformatf("u%0d listo", u), 48'(li), 48'(m_listo[u]));
        check($sformatf("u%0d tabla", u), tb_v, m_tabla[u]);
        check($sformatf("u%0d error", u), 48'(er), 48'(m_error[u]));
        check($sformatf("u%0d err_sel", u), 48'(es), 48'(m_err_sel[u]));
        check($sformatf("u%0d err_ent", u), 48'(ee), 48'(m_err_ent[u]));
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        cmp_unit(0, d0_ocupado, d0_act, d0_sel, {d0_e1, d0_e2, d0_e3}, d0_listo, d0_tabla,
                 d0_error, d0_err_sel, d0_err_ent);
        cmp_unit(1, d1_ocupado, d1_act, d1_sel, {d1_e1, d1_e2, d1_e3}, d1_listo, d1_tabla,
                 d1_error, d1_err_sel, d1_err_ent);
    end

    task automatic run_sweep(input int u, input bit spam, output int busy_n, output int listo_n);
        int post;
        busy_n = 0; listo_n = 0; post = -1;
        @(negedge clk); inicio_v[u] = 1'b1;
        @(negedge clk); inicio_v[u] = 1'b0;
        for (int c = 0; c < 400 && post != 0; c++) begin
            logic oc, li;
            oc = (u == 0) ? d0_ocupado : d1_ocupado;
            li = (u == 0) ? d0_listo : d1_listo;
            if (oc) busy_n++;
            if (li) begin
                listo_n++;
                if (post < 0) post = 4;
            end
            inicio_v[u] = spam && oc && (c % 7 == 3);
            @(negedge clk);
            if (post > 0) post--;
        end
        inicio_v[u] = 1'b0;
        check($sformatf("u%0d sweep timeout", u), 48'(post < 0), 48'd0);
    endtask

    initial begin
        int b, l, found;
        rst = 1'b1; inicio_v = 2'b00; cancel_v = 2'b00; flt_xor3 = 1'b0; flt_nor0 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ocupado", 48'(d0_ocupado), 48'd0);
        check("reset tabla", d0_tabla, 48'd0);
        check("reset sel", 48'(d0_sel), 48'd0);
        rst = 1'b0;

        // single-function sweep with one settle cycle
        run_sweep(1, 1'b0, b, l);
        check("u1 busy cycles", 48'(b), 48'd16);
        check("u1 listo count", 48'(l), 48'd1);
        check("u1 tabla", d1_tabla, 48'h0000_7F00_0000);

        // abort at OR, vector 5
        @(negedge clk); inicio_v[0] = 1'b1;
        @(negedge clk); inicio_v[0] = 1'b0;
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            if (d0_sel == 3'd2 && {d0_e1, d0_e2, d0_e3} == 3'd5) begin
                cancel_v[0] = 1'b1; found = 1;
            end
            @(negedge clk);
        end
        cancel_v[0] = 1'b0;
        check("cancel reached", 48'(found), 48'd1);
        check("cancel ocupado", 48'(d0_ocupado), 48'd0);
        check("cancel act", 48'(d0_act), 48'd0);
        check("cancel listo", 48'(d0_listo), 48'd0);
        check("cancel and row", 48'(d0_tabla[7:0]), 48'h80);
        check("cancel or low", 48'(d0_tabla[12:8]), 48'h1E);
        check("cancel bit13", 48'(d0_tabla[13]), 48'd0);
        repeat (4) @(negedge clk);

        // full sweep while inicio keeps pulsing
        run_sweep(0, 1'b1, b, l);
        check("full busy cycles", 48'(b), 48'd144);
        check("full listo count", 48'(l), 48'd1);
        check("full tabla", d0_tabla, 48'h6901_7F96_FE80);
        check("full error", 48'(d0_error), 48'd0);
        check("full act", 48'(d0_act), 48'd0);

        // faulty XOR v3 and NOR v0
        flt_xor3 = 1'b1; flt_nor0 = 1'b1;
        run_sweep(0, 1'b0, b, l);
        check("fault error", 48'(d0_error), 48'd1);
        check("fault err_sel", 48'(d0_err_sel), 48'd3);
        check("fault err_ent", 48'(d0_err_ent), 48'd3);
        check("fault tabla", d0_tabla, 48'h6900_7F9E_FE80);
        flt_xor3 = 1'b0; flt_nor0 = 1'b0;

        // asynchronous reset during the first capture cycle
        @(negedge clk); inicio_v[0] = 1'b1;
        @(negedge clk); inicio_v[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async ocupado", 48'(d0_ocupado), 48'd0);
        check("async act", 48'(d0_act), 48'd0);
        check("async tabla", d0_tabla, 48'd0);
        check("async error", 48'(d0_error), 48'd0);
        @(negedge clk); rst = 1'b0;

        run_sweep(0, 1'b0, b, l);
        check("post-reset busy", 48'(b), 48'd144);
        check("post-reset tabla", d0_tabla, 48'h6901_7F96_FE80);
        check("post-reset error", 48'(d0_error), 48'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
